// File: rtl/te_pkg.sv
// Shared definitions for the tracking-engine state buffer port.
// Holds the engine channel geometry, default bus widths, the host FSM
// state encoding and the fill tag payload carried alongside fill data.
package te_pkg;

    localparam int unsigned TE_DATA_W       = 32;
    localparam int unsigned TE_ADDR_W       = 10;
    localparam int unsigned WORD_W          = 5;
    localparam int unsigned PCH_W           = 2;
    localparam int unsigned STALL_CNT_W     = 16;

    // Engine channel geometry: words used per logic channel, first dumped word
    localparam int unsigned STATE_WORDS     = 24;
    localparam int unsigned DUMP_FIRST_WORD = 6;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_DONE = 1'b1
    } host_state_e;

    // Tag returned with each fill word
    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [PCH_W-1:0]  channel;
    } fill_tag_t;

endpackage

// File: rtl/te_fill_tag_pipe.sv
// Fill read tag pipeline: remembers that a fill read was issued this cycle
// and which word / physical channel it belongs to, so the tag lines up with
// the SRAM read data one cycle later.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   rd_accept   engine fill read accepted this cycle
//   rd_word     word index of the accepted read
//   rd_channel  physical channel of the accepted read
//   pend        read issued last cycle (fill data valid now)
//   tag         word/channel tag of the read issued last cycle
module te_fill_tag_pipe
    import te_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_accept,
    input  logic [WORD_W-1:0] rd_word,
    input  logic [PCH_W-1:0]  rd_channel,
    output logic              pend,
    output fill_tag_t         tag
);

    // Tag only follows accepted reads; it holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            tag  <= '0;
        end else begin
            pend <= rd_accept;
            if (rd_accept) begin
                tag <= fill_tag_t'{word: rd_word, channel: rd_channel};
            end
        end
    end

endmodule

// File: rtl/te_state_buffer_port.sv
// Single-port responder for the tracking-engine state buffer SRAM.
// The fill/dump sequencer owns the SRAM whenever it requests it (it cannot
// stall); host accesses are slotted into idle engine cycles.
// Optional feature macro: TE_STATE_BUF_STALL_CNT_EN adds host_stall_cnt,
// a saturating count of cycles the host was blocked by the engine.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   state_rd/state_wr           engine fill read / dump write request
//   state_addr                  engine address {logic_ch, word}
//   physical_channel_index      physical channel being filled/dumped
//   dump_wdata                  dump write data
//   fill_valid/data/word/channel  fill read return, 1 cycle after read
//   host_cs/we/addr/wdata       host request, held until host_ready
//   host_rdata/host_ready       host completion (ready is a 1-cycle pulse)
//   eng_conflict                sticky: read and write requested together
//   host_stall_cnt              (macro only) blocked host cycle count
//   sram_en/we/addr/wdata       SRAM port, combinational from requests
//   sram_rdata                  SRAM read data, 1-cycle latency
module te_state_buffer_port
    import te_pkg::*;
#(
    parameter int unsigned DATA_W = TE_DATA_W,
    parameter int unsigned ADDR_W = TE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              state_rd,
    input  logic              state_wr,
    input  logic [ADDR_W-1:0] state_addr,
    input  logic [PCH_W-1:0]  physical_channel_index,
    input  logic [DATA_W-1:0] dump_wdata,
    output logic              fill_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [WORD_W-1:0] fill_word,
    output logic [PCH_W-1:0]  fill_channel,
    input  logic              host_cs,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ready,
    output logic              eng_conflict,
`ifdef TE_STATE_BUF_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] host_stall_cnt,
`endif
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    host_state_e       state_q;
    host_state_e       state_nxt;
    logic              host_grant_c;
    logic              eng_req_c;
    logic              rd_accept_c;
    logic              host_we_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              eng_conflict_q;
    logic              rd_pend;
    fill_tag_t         fill_tag;

    assign eng_req_c   = state_rd | state_wr;
    // A read colliding with a write is dropped; the write wins
    assign rd_accept_c = state_rd & ~state_wr;

    // Host FSM next state / grant; grant is held off during reset so the
    // SRAM enable drops as soon as reset asserts
    always_comb begin
        state_nxt    = state_q;
        host_grant_c = 1'b0;
        host_ready   = 1'b0;
        case (state_q)
            H_IDLE: begin
                if (host_cs && !eng_req_c && !rst) begin
                    host_grant_c = 1'b1;
                    state_nxt    = H_DONE;
                end
            end
            H_DONE: begin
                host_ready = 1'b1;
                state_nxt  = H_IDLE;
            end
            default: state_nxt = H_IDLE;
        endcase
    end

    // Host FSM state, captured transfer direction, read data hold, conflict flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= H_IDLE;
            host_we_q      <= 1'b0;
            host_rdata_q   <= '0;
            eng_conflict_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (host_grant_c) begin
                host_we_q <= host_we;
            end
            if (state_q == H_DONE && !host_we_q) begin
                host_rdata_q <= sram_rdata;
            end
            if (state_rd && state_wr) begin
                eng_conflict_q <= 1'b1;
            end
        end
    end

    // Read data arrives from the SRAM in the H_DONE cycle; show it together
    // with host_ready and keep it afterwards (writes leave it unchanged)
    assign host_rdata   = (state_q == H_DONE && !host_we_q) ? sram_rdata : host_rdata_q;
    assign eng_conflict = eng_conflict_q;

    // SRAM port mux: engine write, then engine read, then host
    always_comb begin
        sram_en    = eng_req_c | host_grant_c;
        sram_we    = 1'b0;
        sram_addr  = host_addr;
        sram_wdata = host_wdata;
        if (state_wr) begin
            sram_we    = 1'b1;
            sram_addr  = state_addr;
            sram_wdata = dump_wdata;
        end else if (state_rd) begin
            sram_addr  = state_addr;
        end else if (host_grant_c) begin
            sram_we    = host_we;
        end
    end

    te_fill_tag_pipe u_fill_pipe (
        .clk        (clk),
        .rst        (rst),
        .rd_accept  (rd_accept_c),
        .rd_word    (state_addr[WORD_W-1:0]),
        .rd_channel (physical_channel_index),
        .pend       (rd_pend),
        .tag        (fill_tag)
    );

    assign fill_valid   = rd_pend;
    assign fill_data    = sram_rdata;
    assign fill_word    = fill_tag.word;
    assign fill_channel = fill_tag.channel;

`ifdef TE_STATE_BUF_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Blocked-host cycle counter; a host write to the top address clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (host_grant_c && host_we && host_addr == {ADDR_W{1'b1}}) begin
            stall_cnt_q <= '0;
        end else if (state_q == H_IDLE && host_cs && eng_req_c && stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign host_stall_cnt = stall_cnt_q;
`endif

endmodule
